customer_dispense: RTL and testbench

Customer-side purchase controller for the vending machine: the counterpart of the owner restock path. While `mode` is 0 it accepts an order, checks stock, collects coins, pulses the dispenser once per item, writes back the decremented stock and returns change. Stock is owned by the supply register and is updated only through the `new_supply`/`supply_we` write-back.

---
 rtl/customer_dispense.sv | 141 ++++++++++++++
 tb/tb_customer_dispense.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/customer_dispense.sv
// Customer purchase controller: order admission, coin collection, per-item dispense,
// stock write-back and change return. Define CUSTOMER_TIMEOUT_EN for the idle auto-cancel.
module customer_dispense #(
   parameter logic [3:0] PRICE   = 4'd3,
   parameter logic [7:0] TIMEOUT = 8'd20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mode,
   input  logic [3:0] machine_supply,
   input  logic [3:0] quantity,
   input  logic       order,
   input  logic       coin_valid,
   input  logic [3:0] coin_value,
   input  logic       cancel,
   output logic [3:0] new_supply,
   output logic       supply_we,
   output logic       dispense,
   output logic [7:0] change,
   output logic       change_valid,
   output logic       redlight,
   output logic       busy,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

   state_t     state;
   logic [3:0] qty_q;
   logic [3:0] snap_q;
   logic [3:0] vend_cnt;
   logic [7:0] cost_q;
   logic [7:0] credit_q;
   logic [8:0] coin_sum;
   logic [7:0] credit_next;
   logic [7:0] order_cost;
   logic       timeout_hit;

   assign dbg_state = state;

   // All strobes (order, coin_valid, cancel in; supply_we, change_valid, redlight out)
   // are single-cycle pulses with no back-pressure; data is valid only with its strobe.
   always_comb begin
      coin_sum    = {1'b0, credit_q} + {5'b0, coin_value};
      credit_next = credit_q;
      if (coin_valid)
         credit_next = coin_sum[8] ? 8'hFF : coin_sum[7:0];
      order_cost  = {4'b0, quantity} * {4'b0, PRICE};
   end

`ifdef CUSTOMER_TIMEOUT_EN
   logic [7:0] idle_cnt;

   assign timeout_hit = (state == COLLECT) && !coin_valid && (idle_cnt == TIMEOUT - 8'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         idle_cnt <= 8'd0;
      else if (state != COLLECT || coin_valid)
         idle_cnt <= 8'd0;
      else if (!timeout_hit)
         idle_cnt <= idle_cnt + 8'd1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         qty_q        <= 4'd0;
         snap_q       <= 4'd0;
         vend_cnt     <= 4'd0;
         cost_q       <= 8'd0;
         credit_q     <= 8'd0;
         new_supply   <= 4'd0;
         supply_we    <= 1'b0;
         dispense     <= 1'b0;
         change       <= 8'd0;
         change_valid <= 1'b0;
         redlight     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         redlight     <= 1'b0;
         supply_we    <= 1'b0;
         change_valid <= 1'b0;
         case (state)
            IDLE: begin
               dispense <= 1'b0;
               busy     <= 1'b0;
               if (order && !mode) begin
                  if (quantity == 4'd0 || quantity > machine_supply) begin
                     redlight <= 1'b1;
                  end else begin
                     qty_q    <= quantity;
                     snap_q   <= machine_supply;
                     cost_q   <= order_cost;
                     credit_q <= 8'd0;
                     busy     <= 1'b1;
                     state    <= COLLECT;
                  end
               end
            end
            COLLECT: begin
               credit_q <= credit_next;
               // Abort has priority over a coin that completes payment in the same cycle.
               if (cancel || mode || timeout_hit) begin
                  change_valid <= 1'b1;
                  change       <= credit_next;
                  state        <= CHANGE;
               end else if (credit_next >= cost_q) begin
                  dispense <= 1'b1;
                  vend_cnt <= qty_q;
                  state    <= VEND;
               end
            end
            VEND: begin
               if (vend_cnt > 4'd1) begin
                  vend_cnt <= vend_cnt - 4'd1;
               end else if (vend_cnt == 4'd1) begin
                  dispense   <= 1'b0;
                  supply_we  <= 1'b1;
                  new_supply <= snap_q - qty_q;
                  vend_cnt   <= 4'd0;
               end else begin
                  change_valid <= 1'b1;
                  change       <= credit_q - cost_q;
                  state        <= CHANGE;
               end
            end
            CHANGE: begin
               credit_q <= 8'd0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_customer_dispense.sv
// Randomized bench for customer_dispense: a transaction-level purchase model predicts
// refunds, change and stock write-back; a monitor scores them against expected queues.
module tb_customer_dispense;

   localparam int PRICE   = 3;
   localparam int TIMEOUT = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mode = 1'b0;
   logic [3:0] machine_supply = 4'd0;
   logic [3:0] quantity = 4'd0;
   logic       order = 1'b0;
   logic       coin_valid = 1'b0;
   logic [3:0] coin_value = 4'd0;
   logic       cancel = 1'b0;
   logic [3:0] new_supply;
   logic       supply_we;
   logic       dispense;
   logic [7:0] change;
   logic       change_valid;
   logic       redlight;
   logic       busy;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int disp_total = 0;

   logic [7:0] exp_q[$];
   logic [3:0] sup_q[$];
   int         coin_plan[$];

   customer_dispense #(.PRICE(4'(PRICE)), .TIMEOUT(8'(TIMEOUT))) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .machine_supply(machine_supply),
      .quantity(quantity), .order(order), .coin_valid(coin_valid), .coin_value(coin_value),
      .cancel(cancel), .new_supply(new_supply), .supply_we(supply_we), .dispense(dispense),
      .change(change), .change_valid(change_valid), .redlight(redlight), .busy(busy),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (dispense) disp_total++;
         if (supply_we) begin
            if (sup_q.size() == 0) check("supply_we_unexpected", 1, 0);
            else check("new_supply", 32'(new_supply), 32'(sup_q.pop_front()));
         end
         if (change_valid) begin
            if (exp_q.size() == 0) check("change_valid_unexpected", 1, 0);
            else check("change", 32'(change), 32'(exp_q.pop_front()));
         end
      end
   end

   // One customer transaction, predicted from the purchase rules; entered and left at a negedge.
   task automatic purchase(input logic [3:0] sup, input logic [3:0] q, input int cancel_at,
                           input int owner_at);
      int  cost, credit, ncoin, v, d0;
      bit  done, paid;
      cost = int'(q) * PRICE;
      d0 = disp_total;
      if ($urandom_range(0, 1) == 1) begin
         coin_valid = 1'b1; coin_value = 4'($urandom_range(1, 15));
         @(negedge clk); coin_valid = 1'b0;
      end
      machine_supply = sup; quantity = q; order = 1'b1;
      @(negedge clk); order = 1'b0;
      if (q == 4'd0 || q > sup) begin
         check("reject_redlight", redlight, 1);
         check("reject_busy", busy, 0);
         @(negedge clk);
         check("reject_redlight_len", redlight, 0);
         check("reject_busy2", busy, 0);
         return;
      end
      check("order_busy", busy, 1);
      check("order_redlight", redlight, 0);
      credit = 0; ncoin = 0; done = 0; paid = 0;
      while (!done) begin
         repeat ($urandom_range(0, 3)) begin
            if ($urandom_range(0, 3) == 0) begin
               order = 1'b1; quantity = 4'($urandom_range(1, 15));
            end
            @(negedge clk); order = 1'b0;
         end
         if (owner_at != 0 && ncoin == owner_at) begin
            exp_q.push_back(8'(credit));
            mode = 1'b1;
            @(negedge clk); mode = 1'b0;
            check("abort_change_valid", change_valid, 1);
            check("abort_dispense", dispense, 0);
            done = 1;
         end else begin
            if (coin_plan.size() > 0) v = coin_plan.pop_front();
            else v = $urandom_range(1, 5);
            credit = (credit + v > 255) ? 255 : credit + v;
            ncoin++;
            coin_valid = 1'b1; coin_value = 4'(v);
            if (ncoin == cancel_at) begin
               cancel = 1'b1;
               exp_q.push_back(8'(credit));
               done = 1;
            end else if (credit >= cost) begin
               sup_q.push_back(sup - q);
               exp_q.push_back(8'(credit - cost));
               paid = 1; done = 1;
            end
            @(negedge clk); coin_valid = 1'b0; cancel = 1'b0;
            if (done && !paid) begin
               check("cancel_change_valid", change_valid, 1);
               check("cancel_dispense", dispense, 0);
            end
         end
      end
      if (paid) begin
         check("dispense_first", dispense, 1);
         for (int i = 2; i <= int'(q); i++) begin
            cancel = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("dispense_run", dispense, 1);
         end
         cancel = 1'b0;
         @(negedge clk);
         check("dispense_end", dispense, 0);
         check("supply_we", supply_we, 1);
         @(negedge clk);
         check("change_valid", change_valid, 1);
         check("busy_in_change", busy, 1);
         @(negedge clk);
         check("busy_after", busy, 0);
         check("dispense_count", disp_total - d0, int'(q));
      end else begin
         check("abort_busy", busy, 1);
         @(negedge clk);
         check("abort_busy_after", busy, 0);
         check("abort_change_len", change_valid, 0);
         check("abort_no_dispense", disp_total - d0, 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got 1 expected 0");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_dispense", dispense, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_change_valid", change_valid, 0);
      check("post_rst_supply_we", supply_we, 0);
      check("post_rst_redlight", redlight, 0);

      coin_plan = '{5, 4};
      purchase(4'd12, 4'd2, 0, 0);
      purchase(4'd1, 4'd2, 0, 0);
      purchase(4'd1, 4'd0, 0, 0);
      coin_plan = '{4, 2};
      purchase(4'd9, 4'd3, 2, 0);
      coin_plan = '{5};
      purchase(4'd5, 4'd2, 0, 1);

      mode = 1'b1; machine_supply = 4'd12; quantity = 4'd2; order = 1'b1;
      @(negedge clk); order = 1'b0;
      check("owner_order_busy", busy, 0);
      check("owner_order_redlight", redlight, 0);
      @(negedge clk);
      check("owner_order_busy2", busy, 0);
      mode = 1'b0;

      coin_plan = '{3};
      purchase(4'd4, 4'd1, 0, 0);

      // Idle in COLLECT after a partial payment.
      machine_supply = 4'd6; quantity = 4'd1; order = 1'b1;
      @(negedge clk); order = 1'b0;
      coin_valid = 1'b1; coin_value = 4'd2;
`ifdef CUSTOMER_TIMEOUT_EN
      exp_q.push_back(8'd2);
`endif
      @(negedge clk); coin_valid = 1'b0;
      n = 0;
      while (!change_valid && n < 40) begin
         @(negedge clk); n++;
      end
`ifdef CUSTOMER_TIMEOUT_EN
      check("timeout_cycles", (n >= TIMEOUT && n <= TIMEOUT + 1), 1);
      @(negedge clk);
`else
      check("no_timeout", change_valid, 0);
      check("no_timeout_busy", busy, 1);
      exp_q.push_back(8'd2);
      cancel = 1'b1;
      @(negedge clk); cancel = 1'b0;
      check("late_cancel_change_valid", change_valid, 1);
      @(negedge clk);
`endif
      check("idle_return_busy", busy, 0);

      // Reset while vending: everything drops, no refund strobe afterwards.
      machine_supply = 4'd9; quantity = 4'd3; order = 1'b1;
      @(negedge clk); order = 1'b0;
      coin_valid = 1'b1; coin_value = 4'd9;
      @(negedge clk); coin_valid = 1'b0;
      check("pre_rst_dispense", dispense, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_dispense", dispense, 0);
      check("midrst_busy", busy, 0);
      check("midrst_supply_we", supply_we, 0);
      check("midrst_change_valid", change_valid, 0);
      check("midrst_redlight", redlight, 0);
      check("midrst_new_supply", 32'(new_supply), 0);
      check("midrst_change", 32'(change), 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("postrst_no_refund", change_valid, 0);
      end
      coin_plan = '{9};
      purchase(4'd9, 4'd3, 0, 0);

      for (int t = 0; t < 40; t++) begin
         int ca, oa;
         ca = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         oa = (ca == 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
         purchase(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ca, oa);
      end

      repeat (3) @(negedge clk);
      check("sup_q_drained", sup_q.size(), 0);
      check("exp_q_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
